// File: rtl/wide_inst_sequencer_pkg.sv
// Shared definitions for the Thumb halfword-to-instruction sequencer.
// Holds widths, two-word prefix encodings, the sequencer state enum and the decode slot struct.
package wide_inst_sequencer_pkg;

  localparam int WORD            = 32;
  localparam int HALF_WORD       = 16;
  localparam int PC_W            = 32;
  localparam int HALFWORD_OFFSET = 2;

  localparam logic [4:0] TWO_WORD_INST_1 = 5'b11101;
  localparam logic [4:0] TWO_WORD_INST_2 = 5'b11110;
  localparam logic [4:0] TWO_WORD_INST_3 = 5'b11111;

  typedef enum logic {
    EXPECT_FIRST  = 1'b0,
    EXPECT_SECOND = 1'b1
  } wide_seq_state_t;

  typedef struct packed {
    logic                 valid;
    logic [HALF_WORD-1:0] first;
    logic [HALF_WORD-1:0] second;
    logic                 is_32;
    logic [PC_W-1:0]      pc;
    logic                 undef;
  } dec_slot_t;

endpackage

// File: rtl/wide_inst_sequencer_if.sv
// Fetch-side handshake and decode-slot bundle of the wide instruction sequencer.
// slave = sequencer view, master = fetch/decode environment view.
interface wide_inst_sequencer_if;

  logic                                      fetch_valid_i;
  logic [wide_inst_sequencer_pkg::HALF_WORD-1:0] fetch_half_i;
  logic [wide_inst_sequencer_pkg::PC_W-1:0]  fetch_pc_i;
  logic                                      fetch_ready_o;
  logic                                      flush_i;
  logic                                      stall_i;
  logic                                      dec_valid_o;
  logic [wide_inst_sequencer_pkg::HALF_WORD-1:0] dec_first_o;
  logic [wide_inst_sequencer_pkg::HALF_WORD-1:0] dec_second_o;
  logic                                      dec_is_32_o;
  logic [wide_inst_sequencer_pkg::PC_W-1:0]  dec_pc_o;
  logic                                      dec_undef_o;

  modport slave (
    input  fetch_valid_i, fetch_half_i, fetch_pc_i, flush_i, stall_i,
    output fetch_ready_o, dec_valid_o, dec_first_o, dec_second_o,
           dec_is_32_o, dec_pc_o, dec_undef_o
  );

  modport master (
    output fetch_valid_i, fetch_half_i, fetch_pc_i, flush_i, stall_i,
    input  fetch_ready_o, dec_valid_o, dec_first_o, dec_second_o,
           dec_is_32_o, dec_pc_o, dec_undef_o
  );

endinterface

// File: rtl/wide_inst_sequencer_prefix_detect.sv
// Combinational 32-bit Thumb prefix detector (first halfword of a two-word encoding).
// Shared with the fetch alignment logic.
module wide_prefix_detect
  import wide_inst_sequencer_pkg::*;
(
  input  logic [HALF_WORD-1:0] half_i,
  output logic                 is_prefix_o
);

  assign is_prefix_o = half_i[15:11] inside {TWO_WORD_INST_1, TWO_WORD_INST_2, TWO_WORD_INST_3};

endmodule

// File: rtl/wide_inst_sequencer.sv
// Fetch-to-decode halfword sequencer: passes 16-bit instructions, pairs prefix+suffix into one slot.
// Optional suffix sanity check built when WIDE_SEQ_UNDEF_CHECK_EN is defined.
module wide_inst_sequencer
  import wide_inst_sequencer_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  wide_inst_sequencer_if.slave   bus
);

  wide_seq_state_t      state_q, state_d;
  logic [HALF_WORD-1:0] pfx_q, pfx_d;
  logic [PC_W-1:0]      pfx_pc_q, pfx_pc_d;
  dec_slot_t            slot_q, slot_d;

  logic adv, accept, is_prefix;

  wide_prefix_detect u_pfx (
    .half_i      (bus.fetch_half_i),
    .is_prefix_o (is_prefix)
  );

  // Slot may advance when empty or decode is consuming it; flush and reset block acceptance.
  assign adv               = ~slot_q.valid | ~bus.stall_i;
  assign bus.fetch_ready_o = adv & ~bus.flush_i & rst_n_i;
  assign accept            = bus.fetch_valid_i & bus.fetch_ready_o;

  always_comb begin
    state_d  = state_q;
    pfx_d    = pfx_q;
    pfx_pc_d = pfx_pc_q;
    slot_d   = slot_q;
    if (bus.flush_i) begin
      state_d  = EXPECT_FIRST;
      pfx_d    = '0;
      pfx_pc_d = '0;
      slot_d   = '0;
    end else if (adv) begin
      slot_d = '0;
      if (accept) begin
        if (state_q == EXPECT_SECOND) begin
          slot_d.valid  = 1'b1;
          slot_d.first  = pfx_q;
          slot_d.second = bus.fetch_half_i;
          slot_d.is_32  = 1'b1;
          slot_d.pc     = pfx_pc_q;
`ifdef WIDE_SEQ_UNDEF_CHECK_EN
          slot_d.undef  = (bus.fetch_half_i[15:14] != 2'b11);
`endif
          state_d       = EXPECT_FIRST;
        end else if (is_prefix) begin
          pfx_d    = bus.fetch_half_i;
          pfx_pc_d = bus.fetch_pc_i;
          state_d  = EXPECT_SECOND;
        end else begin
          slot_d.valid = 1'b1;
          slot_d.first = bus.fetch_half_i;
          slot_d.pc    = bus.fetch_pc_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= EXPECT_FIRST;
      pfx_q    <= '0;
      pfx_pc_q <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      pfx_q    <= pfx_d;
      pfx_pc_q <= pfx_pc_d;
      slot_q   <= slot_d;
    end
  end

  assign bus.dec_valid_o  = slot_q.valid;
  assign bus.dec_first_o  = slot_q.first;
  assign bus.dec_second_o = slot_q.second;
  assign bus.dec_is_32_o  = slot_q.is_32;
  assign bus.dec_pc_o     = slot_q.pc;
  assign bus.dec_undef_o  = slot_q.undef;

endmodule

// File: tb/tb_wide_inst_sequencer.sv
// Bench for wide_inst_sequencer: directed vectors, literal checks and a per-cycle instruction-level model.
module tb_wide_inst_sequencer;

`ifdef WIDE_SEQ_UNDEF_CHECK_EN
  localparam bit UNDEF_EN = 1'b1;
`else
  localparam bit UNDEF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wide_inst_sequencer_if bus ();

  wide_inst_sequencer dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic last_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instruction-level model: an optional pending prefix plus the expected decode slot.
  bit          m_pend = 0;
  logic [15:0] m_pfx = '0;
  logic [31:0] m_pfx_pc = '0;
  bit          m_valid = 0, m_is32 = 0, m_undef = 0;
  logic [15:0] m_first = '0, m_second = '0;
  logic [31:0] m_pc = '0;

  function automatic bit two_word(input logic [15:0] h);
    return (h[15:13] == 3'b111) && (h[12:11] != 2'b00);
  endfunction

  initial begin
    bit exp_ready;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ready = rst_n && !bus.flush_i && (!m_valid || !bus.stall_i);
      chk("ready", 32'(bus.fetch_ready_o), 32'(exp_ready));
      chk("valid", 32'(bus.dec_valid_o), 32'(m_valid));
      chk("is_32", 32'(bus.dec_is_32_o), 32'(m_is32));
      chk("undef", 32'(bus.dec_undef_o), 32'(m_undef));
      if (m_valid) begin
        chk("first", 32'(bus.dec_first_o), 32'(m_first));
        chk("second", 32'(bus.dec_second_o), 32'(m_second));
        chk("pc", bus.dec_pc_o, m_pc);
      end
      if (!rst_n || bus.flush_i) begin
        m_pend = 0; m_pfx = '0; m_pfx_pc = '0;
        m_valid = 0; m_is32 = 0; m_undef = 0; m_first = '0; m_second = '0; m_pc = '0;
      end else if (!m_valid || !bus.stall_i) begin
        m_valid = 0; m_is32 = 0; m_undef = 0; m_first = '0; m_second = '0; m_pc = '0;
        if (bus.fetch_valid_i) begin
          if (m_pend) begin
            m_valid = 1; m_is32 = 1; m_first = m_pfx; m_second = bus.fetch_half_i; m_pc = m_pfx_pc;
            m_undef = UNDEF_EN && (bus.fetch_half_i[15:14] != 2'b11);
            m_pend = 0;
          end else if (two_word(bus.fetch_half_i)) begin
            m_pend = 1; m_pfx = bus.fetch_half_i; m_pfx_pc = bus.fetch_pc_i;
          end else begin
            m_valid = 1; m_first = bus.fetch_half_i; m_pc = bus.fetch_pc_i;
          end
        end
      end
    end
  end

  // Drive one cycle of inputs, sample the combinational ready, then step past the edge.
  task automatic cyc(input bit v, input logic [15:0] h, input logic [31:0] pc,
                     input bit st, input bit fl);
    bus.fetch_valid_i = v;
    bus.fetch_half_i  = h;
    bus.fetch_pc_i    = pc;
    bus.stall_i       = st;
    bus.flush_i       = fl;
    #1 last_ready = bus.fetch_ready_o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fetch_valid_i = 1'b1;
    bus.fetch_half_i  = 16'h2005;
    bus.fetch_pc_i    = 32'h0;
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 32'(bus.dec_valid_o), 32'd0);
    chk("rst_pc", bus.dec_pc_o, 32'd0);
    chk("rst_first", 32'(bus.dec_first_o), 32'd0);
    chk("rst_ready", 32'(bus.fetch_ready_o), 32'd0);
    rst_n = 1'b1;

    cyc(1, 16'h2005, 32'h100, 0, 0);
    chk("t1_valid", 32'(bus.dec_valid_o), 32'd1);
    chk("t1_first", 32'(bus.dec_first_o), 32'h2005);
    chk("t1_is32", 32'(bus.dec_is_32_o), 32'd0);
    chk("t1_pc", bus.dec_pc_o, 32'h100);

    cyc(1, 16'hF000, 32'h200, 0, 0);
    chk("t2_bubble", 32'(bus.dec_valid_o), 32'd0);
    cyc(1, 16'hF802, 32'h202, 0, 0);
    chk("t2_valid", 32'(bus.dec_valid_o), 32'd1);
    chk("t2_first", 32'(bus.dec_first_o), 32'hF000);
    chk("t2_second", 32'(bus.dec_second_o), 32'hF802);
    chk("t2_is32", 32'(bus.dec_is_32_o), 32'd1);
    chk("t2_pc", bus.dec_pc_o, 32'h200);

    cyc(1, 16'h2005, 32'h300, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'h2006, 32'h302, 1, 0);
      chk("t3_stall_ready", 32'(last_ready), 32'd0);
      chk("t3_stall_first", 32'(bus.dec_first_o), 32'h2005);
      chk("t3_stall_pc", bus.dec_pc_o, 32'h300);
    end
    cyc(1, 16'h2006, 32'h302, 0, 0);
    chk("t3_rel_first", 32'(bus.dec_first_o), 32'h2006);
    chk("t3_rel_pc", bus.dec_pc_o, 32'h302);
    cyc(0, 16'h0000, 32'h0, 0, 0);
    chk("t3_idle", 32'(bus.dec_valid_o), 32'd0);

    cyc(1, 16'hF000, 32'h400, 0, 0);
    cyc(1, 16'hF802, 32'h402, 0, 1);
    chk("t4_flush_ready", 32'(last_ready), 32'd0);
    chk("t4_flush_valid", 32'(bus.dec_valid_o), 32'd0);
    cyc(1, 16'h4770, 32'h404, 0, 0);
    chk("t4_valid", 32'(bus.dec_valid_o), 32'd1);
    chk("t4_first", 32'(bus.dec_first_o), 32'h4770);
    chk("t4_is32", 32'(bus.dec_is_32_o), 32'd0);

    cyc(1, 16'h4770, 32'h406, 1, 1);
    chk("t4b_stall_flush", 32'(bus.dec_valid_o), 32'd0);

    cyc(1, 16'hF7FF, 32'h500, 0, 0);
    rst_n = 1'b0;
    cyc(0, 16'h0000, 32'h0, 0, 0);
    rst_n = 1'b1;
    cyc(1, 16'h2005, 32'h504, 0, 0);
    chk("t5_valid", 32'(bus.dec_valid_o), 32'd1);
    chk("t5_is32", 32'(bus.dec_is_32_o), 32'd0);
    chk("t5_first", 32'(bus.dec_first_o), 32'h2005);

    cyc(1, 16'hF000, 32'h600, 0, 0);
    cyc(1, 16'h2005, 32'h602, 0, 0);
    chk("t6_is32", 32'(bus.dec_is_32_o), 32'd1);
    chk("t6_second", 32'(bus.dec_second_o), 32'h2005);
    chk("t6_undef", 32'(bus.dec_undef_o), 32'(UNDEF_EN));
    cyc(1, 16'h4770, 32'h604, 0, 0);
    chk("t6_undef_clr", 32'(bus.dec_undef_o), 32'd0);

    cyc(1, 16'hF000, 32'h700, 0, 0);
    cyc(1, 16'hF800, 32'h702, 0, 0);
    chk("t7_undef_ok", 32'(bus.dec_undef_o), 32'd0);
    cyc(0, 16'h0000, 32'h0, 0, 0);
    cyc(0, 16'h0000, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
